// File: rtl/noc_alloc_pkg.sv
// Shared types and helpers for the NoC per-output switch allocator.
package noc_alloc_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } alloc_state_t;

   localparam int LOCAL_PORT = 0;

   function automatic int credit_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/noc_output_allocator_rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after ptr, cyclic.
module rr_arbiter #(
   parameter int N     = 5,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     eligible,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     winner_oh,
   output logic [IDX_W-1:0] winner_idx,
   output logic             any
);

   always_comb begin
      int idx;
      idx        = 0;
      winner_idx = '0;
      any        = |eligible;
      // Walk offsets from farthest to nearest so the nearest eligible index is the last one written.
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N;
         if (eligible[idx]) begin
            winner_idx = IDX_W'(idx);
         end
      end
      winner_oh             = '0;
      winner_oh[winner_idx] = any;
   end

endmodule

// File: rtl/noc_output_allocator.sv
// Per-output wormhole switch allocator with round-robin arbitration and downstream credit tracking.
// Optional NOC_ALLOC_PERF_EN adds a saturating credit-stall cycle counter (stall_cycles).
//
// state  | meaning
// IDLE   | output free; arbitrate among eligible inputs each cycle
// LOCKED | output held by owner until its tail flit crosses
module noc_output_allocator
   import noc_alloc_pkg::*;
#(
   parameter int NUM_INPUTS        = 5,
   parameter int FLIT_BUFFER_DEPTH = 8,
   parameter int CREDIT_WIDTH      = credit_width(FLIT_BUFFER_DEPTH)
) (
   input  logic                    clk_noc,
   input  logic                    rst_n,
   input  logic [NUM_INPUTS-1:0]   req,
   input  logic [NUM_INPUTS-1:0]   req_is_tail,
   input  logic [NUM_INPUTS-1:0]   turn_disable,
   output logic [NUM_INPUTS-1:0]   grant,
   output logic                    send_out,
   input  logic                    credit_in,
   output logic [CREDIT_WIDTH-1:0] credits,
   output logic                    locked,
   output logic                    credit_err
`ifdef NOC_ALLOC_PERF_EN
   ,output logic [31:0]            stall_cycles
`endif
);

   localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

   alloc_state_t            state_q, state_d;
   logic [IDX_W-1:0]        owner_q, owner_d;
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
   logic                    credit_err_q, credit_err_d;

   logic [NUM_INPUTS-1:0]   eligible;
   logic [NUM_INPUTS-1:0]   win_oh;
   logic [IDX_W-1:0]        win_idx;
   logic                    win_any;
   logic                    credit_ok;
   logic                    credit_full;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
      return (int'(i) == NUM_INPUTS - 1) ? '0 : i + 1'b1;
   endfunction

   assign eligible    = req & ~turn_disable;
   assign credit_ok   = (credits_q != '0);
   assign credit_full = (credits_q == CREDIT_MAX);

   rr_arbiter #(
      .N     (NUM_INPUTS),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .eligible   (eligible),
      .ptr        (rr_ptr_q),
      .winner_oh  (win_oh),
      .winner_idx (win_idx),
      .any        (win_any)
   );

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      grant    = '0;
      unique case (state_q)
         IDLE: begin
            if (credit_ok && win_any) begin
               grant = win_oh;
               if (req_is_tail[win_idx]) begin
                  rr_ptr_d = wrap_inc(win_idx);
               end else begin
                  state_d = LOCKED;
                  owner_d = win_idx;
               end
            end
         end
         LOCKED: begin
            if (credit_ok && req[owner_q]) begin
               grant[owner_q] = 1'b1;
               if (req_is_tail[owner_q]) begin
                  state_d  = IDLE;
                  rr_ptr_d = wrap_inc(owner_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Keep the link quiet while reset is held, even with requests present.
      if (!rst_n) begin
         grant = '0;
      end
   end

   assign send_out = |grant;

   always_comb begin
      credits_d    = credits_q;
      credit_err_d = credit_err_q;
      unique case ({send_out, credit_in})
         2'b10:   credits_d = credits_q - 1'b1;
         2'b01: begin
            if (credit_full) begin
               credit_err_d = 1'b1;
            end else begin
               credits_d = credits_q + 1'b1;
            end
         end
         default: credits_d = credits_q;
      endcase
   end

   always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         owner_q      <= IDX_W'(LOCAL_PORT);
         rr_ptr_q     <= IDX_W'(LOCAL_PORT);
         credits_q    <= CREDIT_MAX;
         credit_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         rr_ptr_q     <= rr_ptr_d;
         credits_q    <= credits_d;
         credit_err_q <= credit_err_d;
      end
   end

   assign credits    = credits_q;
   assign locked     = (state_q == LOCKED);
   assign credit_err = credit_err_q;

`ifdef NOC_ALLOC_PERF_EN
   logic [31:0] stall_q, stall_d;
   logic        stalled;

   assign stalled = !credit_ok && ((state_q == IDLE) ? (|eligible) : req[owner_q]);

   always_comb begin
      stall_d = stall_q;
      if (stalled && (stall_q != '1)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: doc/noc_output_allocator.md
# noc_output_allocator

Per-output-port switch allocator for the NoC router. Arbitrates among the router's input ports competing for one output, using round-robin arbitration. Locks the output to the winning input until that packet's tail flit has crossed (wormhole switching). Tracks downstream buffer credits so a flit is only sent when the next hop has space. One instance sits beside each router output, between route compute and the crossbar/output register.

## Interface
Parameters:
- NUM_INPUTS, 5, number of requesting input ports (index 0 = local injection).
- FLIT_BUFFER_DEPTH, 8, downstream input buffer depth; initial and maximum credit count.
- CREDIT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), credit counter width.

Ports:
- clk_noc  in  1  router clock; one clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req  in  NUM_INPUTS  input i has a head-of-queue flit routed to this output.
- req_is_tail  in  NUM_INPUTS  that flit is a packet tail.
- turn_disable  in  NUM_INPUTS  input i must never win this output (quasi-static).
- grant  out  NUM_INPUTS  one-hot; input i's flit crosses this cycle.
- send_out  out  1  OR of grant; flit valid on output link.
- credit_in  in  1  downstream freed one buffer slot.
- credits  out  CREDIT_WIDTH  current credit count.
- locked  out  1  output is mid-packet (state LOCKED).
- credit_err  out  1  sticky; credit_in received while credits == FLIT_BUFFER_DEPTH.

## Operation
- States: IDLE, LOCKED. Registers: state, owner index, round-robin pointer rr_ptr, credit count, credit_err.
- eligible[i] = req[i] & ~turn_disable[i].
- IDLE: if credits > 0 and any eligible, pick the first eligible index at or after rr_ptr (cyclic); grant it.
  - Granted flit is tail: stay IDLE; rr_ptr <= winner+1 mod NUM_INPUTS.
  - Not tail: go LOCKED; owner <= winner.
- LOCKED: grant[owner] = req[owner] & (credits > 0). All other inputs get 0 regardless of req. turn_disable is not consulted.
  - If the owner drops req, the output idles (bubble) and stays LOCKED.
  - When the tail flit is granted: go IDLE; rr_ptr <= owner+1 mod NUM_INPUTS.
- Credits: next = credits - send_out + credit_in.
  - A simultaneous send and credit leaves the count unchanged.
  - At credits == 0, send is blocked even if credit_in is high that cycle. The credit becomes usable next cycle.
  - credit_in at credits == FLIT_BUFFER_DEPTH with no send: count saturates and credit_err is set. Cleared only by reset.
- Reset (async, any state, including mid-packet): state IDLE, owner 0, rr_ptr 0, credits = FLIT_BUFFER_DEPTH, credit_err 0, perf counter 0. Outputs: grant 0, send_out 0, locked 0, credits = FLIT_BUFFER_DEPTH.

## Timing
- grant and send_out are combinational from req, req_is_tail, turn_disable and registered state: zero-cycle allocation, up to one flit per cycle.
- State, credits and rr_ptr update on the rising edge after the grant cycle.
- credits, locked and credit_err are register outputs.
- Back-to-back packets from different inputs: the next packet's head may be granted in the cycle immediately after the previous tail (no dead cycle).
- Credit round trip is external. This block adds no latency to credit_in beyond one register stage.

## Configuration
- NOC_ALLOC_PERF_EN defined: adds output stall_cycles (32 bits), a saturating counter. It increments each cycle that any eligible req (IDLE) or the owner's req (LOCKED) is high, but send_out is 0 because credits == 0. Reset clears it to 0.
- NOC_ALLOC_PERF_EN undefined: the port and counter are absent. Allocation behaviour is identical.

## Structure
- Shared package noc_alloc_pkg holds:
  - enum alloc_state_t {IDLE, LOCKED};
  - function for credit width from depth;
  - constant for the local port index 0.
- Sub-module rr_arbiter (parameter N): inputs eligible vector and pointer; outputs one-hot winner and winner index; purely combinational.
- noc_output_allocator owns all sequential state.

## Test plan
- Reset: after rst_n deassert → credits = 8, grant = 0, locked = 0, credit_err = 0.
- Fairness: req = 5'b11111, all single-flit tails, credit_in held high → grants cycle through inputs 0,1,2,3,4,0 on consecutive cycles.
- Wormhole lock: input 2 sends a 4-flit packet while input 1 continuously requests → grant[2] for 4 flits (locked = 1 between), then grant[1] on the next cycle; input 1 never granted mid-packet.
- Credit exhaustion: depth 8, no credit_in, input 0 streams 10 flits → 8 sent, credits = 0, send_out stays 0. One credit_in pulse → exactly one more flit, sent one cycle after the pulse. With NOC_ALLOC_PERF_EN, stall_cycles counts the stalled cycles.
- Masking: turn_disable = 5'b00010, req = 5'b00010 → no grant for 20 cycles. Then req = 5'b00110 → grant[2].
- Error/reset: credit_in at credits = 8 → credit_err = 1, credits stays 8. Assert rst_n low mid-packet (locked = 1) → immediately locked = 0, grant = 0, credits = 8, credit_err = 0.
